// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate-format enum, RV opcode and shift funct3 constants
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) ();
    import imm_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    imm_fmt_e         out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

endinterface

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RV instruction to immediate/format decoder
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [SHAMT_W-1:0] shamt;
    logic [31:0]        imm32;
    logic               is_shift;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign shamt  = instr[20 +: SHAMT_W];

    always_comb begin
        fmt = FMT_NONE;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:                                  fmt = FMT_S;
            OPC_BRANCH:                                 fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
            OPC_JAL:                                    fmt = FMT_J;
            default:                                    fmt = FMT_NONE;
        endcase
    end

    // Every format is first built as a 32-bit signed value, then widened once.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Shifts carry funct7 in the upper immediate bits; only the shamt is kept.
    assign is_shift = (opcode == OPC_OP_IMM) && ((funct3 == F3_SLLI) || (funct3 == F3_SRXI));

    assign imm     = is_shift ? XLEN'(shamt) : XLEN'(signed'(imm32));
    assign illegal = (fmt == FMT_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate generator with one output register and one skid entry
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    imm_gen_pipe_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } result_t;

    localparam result_t RES_RESET = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    result_t         new_res;
    result_t         out_q;
    result_t         skid_q;
    logic            out_valid_q;
    logic            skid_valid_q;
    logic            in_ready_q;
    logic            accept;
    logic            drain;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (bus.in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign new_res = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: bus.in_tag};
    assign accept  = bus.in_valid && in_ready_q;
    assign drain   = out_valid_q && bus.out_ready;

    // in_ready is simply "skid is empty", registered so it never depends on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_q        <= RES_RESET;
            skid_q       <= RES_RESET;
        end else if (skid_valid_q) begin
            if (drain) begin
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end
        end else if (accept) begin
            if (!out_valid_q || drain) begin
                out_q       <= new_res;
                out_valid_q <= 1'b1;
            end else begin
                skid_q       <= new_res;
                skid_valid_q <= 1'b1;
                in_ready_q   <= 1'b0;
            end
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_illegal = out_q.illegal;
    assign bus.out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed scoreboard bench for imm_gen_pipe
module tb_imm_gen_pipe;
    import imm_pkg::*;

    typedef struct packed {
        logic [31:0] imm;
        imm_fmt_e    fmt;
        logic        illegal;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks_pass;
    int   checks_total;
    exp_t sb[$];
    exp_t cur_exp;
    exp_t got;
    logic [31:0] hold_imm;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) bus ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic send(input logic [31:0] instr, input logic [3:0] tag,
                        input logic [31:0] eimm, input imm_fmt_e efmt, input logic eill);
        logic accepted;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_tag   = tag;
        cur_exp      = '{imm: eimm, fmt: efmt, illegal: eill, tag: tag};
        accepted     = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checks_total++;
        assert (accepted) checks_pass++;
        else $error("FAIL accept_timeout: tag 0x%0h observed in_ready never 1 expected accept", tag);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks_total++;
            assert (sb.size() != 0) checks_pass++;
            else $error("FAIL unexpected_output: observed tag 0x%0h expected no output", bus.out_tag);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check("sb_imm", 64'(bus.out_imm), 64'(got.imm));
                check("sb_fmt", 64'(bus.out_fmt), 64'(got.fmt));
                check("sb_illegal", 64'(bus.out_illegal), 64'(got.illegal));
                check("sb_tag", 64'(bus.out_tag), 64'(got.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        checks_pass    = 0;
        checks_total   = 0;
        cur_exp        = '0;
        bus.in_valid   = 1'b0;
        bus.in_instr   = '0;
        bus.in_tag     = '0;
        bus.out_ready  = 1'b0;
        bus64.in_valid = 1'b0;
        bus64.in_instr = '0;
        bus64.in_tag   = '0;
        bus64.out_ready = 1'b1;
        rst_n          = 1'b1;

        // Reset state, observed before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_imm", 64'(bus.out_imm), 64'd0);
        check("rst_out_fmt", 64'(bus.out_fmt), 64'(FMT_NONE));
        check("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single transactions, output free-running
        bus.out_ready = 1'b1;
        send(32'hFE000EE3, 4'h1, 32'hFFFFFFFC, FMT_B, 1'b0);
        check("lat_out_valid", 64'(bus.out_valid), 64'd1);
        check("lat_out_imm", 64'(bus.out_imm), 64'hFFFFFFFC);
        send(32'hFFF00093, 4'h2, 32'hFFFFFFFF, FMT_I, 1'b0);
        send(32'h4030D093, 4'h3, 32'h00000003, FMT_I, 1'b0);
        send(32'h0230D093, 4'h4, 32'h00000003, FMT_I, 1'b0);
        send(32'h800000B7, 4'h5, 32'h80000000, FMT_U, 1'b0);
        send(32'hFF9FF06F, 4'h6, 32'hFFFFFFF8, FMT_J, 1'b0);
        send(32'hFE000FA3, 4'h7, 32'hFFFFFFFF, FMT_S, 1'b0);
        send(32'h02000123, 4'h8, 32'h00000022, FMT_S, 1'b0);
        send(32'h0000007F, 4'hA, 32'h00000000, FMT_NONE, 1'b1);
        wait_drain();

        // Backpressure: two accepts fill output and skid, third waits
        bus.out_ready = 1'b0;
        send(32'h00100093, 4'h1, 32'h1, FMT_I, 1'b0);
        send(32'h00200093, 4'h2, 32'h2, FMT_I, 1'b0);
        fork
            send(32'h00300093, 4'h3, 32'h3, FMT_I, 1'b0);
            begin
                check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                check("bp_out_tag", 64'(bus.out_tag), 64'h1);
                hold_imm = bus.out_imm;
                @(posedge clk);
                #1;
                check("bp_hold_tag", 64'(bus.out_tag), 64'h1);
                check("bp_hold_imm", 64'(bus.out_imm), 64'(hold_imm));
                check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset while output and skid are both full
        bus.out_ready = 1'b0;
        send(32'h00C00093, 4'hC, 32'hC, FMT_I, 1'b0);
        send(32'h00D00093, 4'hD, 32'hD, FMT_I, 1'b0);
        check("pre_rst_skid_full", 64'(bus.in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("async_rst_out_tag", 64'(bus.out_tag), 64'd0);
        sb.delete();
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(bus.out_valid), 64'd0);
        send(32'h00500093, 4'h5, 32'h5, FMT_I, 1'b0);
        wait_drain();

        // 64-bit datapath: sign extension and 6-bit shamt
        bus64.in_valid = 1'b1;
        bus64.in_instr = 32'h800000B7;
        bus64.in_tag   = 4'h9;
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        check("x64_u_valid", 64'(bus64.out_valid), 64'd1);
        check("x64_u_imm", bus64.out_imm, 64'hFFFFFFFF80000000);
        check("x64_u_tag", 64'(bus64.out_tag), 64'h9);
        bus64.in_valid = 1'b1;
        bus64.in_instr = 32'h0230D093;
        @(posedge clk);
        #1;
        check("x64_shamt", bus64.out_imm, 64'h23);
        bus64.in_instr = 32'hFF9FF06F;
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        check("x64_j_imm", bus64.out_imm, 64'hFFFFFFFFFFFFFFF8);
        check("x64_j_fmt", 64'(bus64.out_fmt), 64'(FMT_J));

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
